// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and sync flush.
// SKID=1 adds a second entry so that up_ready is registered.
module pipe_stage_reg #(
    parameter int DATA_W = 165,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    generate
        if (SKID != 0) begin : g_skid

            state_t              state_q;
            logic                valid_q;
            logic                rdy_q;
            logic [1:0]          occ_q;
            logic [DATA_W-1:0]   main_data_q;
            logic [CTRL_W-1:0]   main_ctrl_q;
            logic [DATA_W-1:0]   skid_data_q;
            logic [CTRL_W-1:0]   skid_ctrl_q;
            logic                accept;
            logic                drain;

            assign accept = up_valid & rdy_q;
            assign drain  = valid_q & dn_ready;

            // Main/skid FSM; every output is a register so dn_ready never reaches up_ready.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    state_q     <= S_EMPTY;
                    valid_q     <= 1'b0;
                    rdy_q       <= 1'b1;
                    occ_q       <= 2'd0;
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else if (flush) begin
                    state_q     <= S_EMPTY;
                    valid_q     <= 1'b0;
                    rdy_q       <= 1'b1;
                    occ_q       <= 2'd0;
                    main_ctrl_q <= '0;
                end else begin
                    unique case (state_q)
                        S_EMPTY: begin
                            if (accept) begin
                                main_data_q <= up_data;
                                main_ctrl_q <= up_ctrl;
                                valid_q     <= 1'b1;
                                occ_q       <= 2'd1;
                                state_q     <= S_ONE;
                            end
                        end
                        S_ONE: begin
                            if (accept && drain) begin
                                main_data_q <= up_data;
                                main_ctrl_q <= up_ctrl;
                            end else if (accept) begin
                                skid_data_q <= up_data;
                                skid_ctrl_q <= up_ctrl;
                                rdy_q       <= 1'b0;
                                occ_q       <= 2'd2;
                                state_q     <= S_FULL;
                            end else if (drain) begin
                                valid_q     <= 1'b0;
                                occ_q       <= 2'd0;
                                state_q     <= S_EMPTY;
                            end
                        end
                        S_FULL: begin
                            if (drain) begin
                                main_data_q <= skid_data_q;
                                main_ctrl_q <= skid_ctrl_q;
                                rdy_q       <= 1'b1;
                                occ_q       <= 2'd1;
                                state_q     <= S_ONE;
                            end
                        end
                        default: begin
                            valid_q <= 1'b0;
                            rdy_q   <= 1'b1;
                            occ_q   <= 2'd0;
                            state_q <= S_EMPTY;
                        end
                    endcase
                end
            end

            assign up_ready  = rdy_q;
            assign dn_valid  = valid_q;
            assign dn_data   = main_data_q;
            assign dn_ctrl   = valid_q ? main_ctrl_q : '0;
            assign occupancy = occ_q;

        end else begin : g_single

            logic                valid_q;
            logic                valid_d;
            logic [DATA_W-1:0]   data_q;
            logic [DATA_W-1:0]   data_d;
            logic [CTRL_W-1:0]   ctrl_q;
            logic [CTRL_W-1:0]   ctrl_d;
            logic                rdy;
            logic                accept;
            logic                drain;

            assign rdy    = dn_ready | ~valid_q;
            assign accept = up_valid & rdy;
            assign drain  = valid_q & dn_ready;

            // Next state: flush squashes, accept reloads, a lone drain empties.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                ctrl_d  = ctrl_q;
                if (flush) begin
                    valid_d = 1'b0;
                    ctrl_d  = '0;
                end else if (accept) begin
                    valid_d = 1'b1;
                    data_d  = up_data;
                    ctrl_d  = up_ctrl;
                end else if (drain) begin
                    valid_d = 1'b0;
                end
            end

            // Single holding register.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    ctrl_q  <= ctrl_d;
                end
            end

            assign up_ready  = rdy;
            assign dn_valid  = valid_q;
            assign dn_data   = data_q;
            assign dn_ctrl   = valid_q ? ctrl_q : '0;
            assign occupancy = {1'b0, valid_q};

        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus,
// each compared against a queue model every cycle.
module tb_pipe_stage_reg;

    localparam int DW = 165;
    localparam int CW = 4;
    localparam int PW = DW + CW;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          flush = 1'b0;
    logic          up_valid = 1'b0;
    logic          dn_ready = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic [CW-1:0] up_ctrl = '0;

    logic          a_up_ready, a_dn_valid;
    logic [DW-1:0] a_dn_data;
    logic [CW-1:0] a_dn_ctrl;
    logic [1:0]    a_occ;
    logic          b_up_ready, b_dn_valid;
    logic [DW-1:0] b_dn_data;
    logic [CW-1:0] b_dn_ctrl;
    logic [1:0]    b_occ;

    logic [PW-1:0] qa[$];
    logic [PW-1:0] qb[$];
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [DW-1:0] A_D = 165'h0AAAA;
    localparam logic [DW-1:0] B_D = 165'h0BBBB;
    localparam logic [DW-1:0] C_D = 165'h0CCCC;
    localparam logic [DW-1:0] D_D = 165'h0DDDD;
    localparam logic [DW-1:0] E_D = 165'h0EEEE;
    localparam logic [DW-1:0] X_D = 165'h01234;
    localparam logic [DW-1:0] Y_D = 165'h05678;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_a (
        .clk(clk), .nrst(nrst), .flush(flush),
        .up_valid(up_valid), .up_ready(a_up_ready),
        .up_data(up_data), .up_ctrl(up_ctrl),
        .dn_valid(a_dn_valid), .dn_ready(dn_ready),
        .dn_data(a_dn_data), .dn_ctrl(a_dn_ctrl),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_b (
        .clk(clk), .nrst(nrst), .flush(flush),
        .up_valid(up_valid), .up_ready(b_up_ready),
        .up_data(up_data), .up_ctrl(up_ctrl),
        .dn_valid(b_dn_valid), .dn_ready(dn_ready),
        .dn_data(b_dn_data), .dn_ctrl(b_dn_ctrl),
        .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Queue model: a stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
    task automatic model_edge();
        bit acc_a, drn_a, acc_b, drn_b;
        acc_a = up_valid && (qa.size() < 2);
        drn_a = (qa.size() > 0) && dn_ready;
        acc_b = up_valid && (dn_ready || qb.size() == 0);
        drn_b = (qb.size() > 0) && dn_ready;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (drn_a) void'(qa.pop_front());
            if (acc_a) qa.push_back({up_ctrl, up_data});
            if (drn_b) void'(qb.pop_front());
            if (acc_b) qb.push_back({up_ctrl, up_data});
        end
    endtask

    task automatic check_all();
        logic [PW-1:0] h;
        logic [CW-1:0] ec;
        h  = (qa.size() != 0) ? qa[0] : '0;
        ec = (qa.size() != 0) ? h[PW-1:DW] : '0;
        chk("a_up_ready", 192'(a_up_ready), 192'(qa.size() < 2));
        chk("a_dn_valid", 192'(a_dn_valid), 192'(qa.size() != 0));
        chk("a_occ", 192'(a_occ), 192'(qa.size()));
        chk("a_dn_ctrl", 192'(a_dn_ctrl), 192'(ec));
        if (qa.size() != 0) chk("a_dn_data", 192'(a_dn_data), 192'(h[DW-1:0]));
        h  = (qb.size() != 0) ? qb[0] : '0;
        ec = (qb.size() != 0) ? h[PW-1:DW] : '0;
        chk("b_up_ready", 192'(b_up_ready), 192'(dn_ready || qb.size() == 0));
        chk("b_dn_valid", 192'(b_dn_valid), 192'(qb.size() != 0));
        chk("b_occ", 192'(b_occ), 192'(qb.size()));
        chk("b_dn_ctrl", 192'(b_dn_ctrl), 192'(ec));
        if (qb.size() != 0) chk("b_dn_data", 192'(b_dn_data), 192'(h[DW-1:0]));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic r, input logic f);
        up_valid = v;
        up_data  = d;
        up_ctrl  = c;
        dn_ready = r;
        flush    = f;
        #1;
    endtask

    task automatic step();
        check_all();
        @(posedge clk);
        if (nrst) model_edge();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset held with traffic present
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd(), 4'hF, 1'b0, 1'b0);
            chk("rst_a_valid", 192'(a_dn_valid), 192'(0));
            chk("rst_a_ctrl", 192'(a_dn_ctrl), 192'(0));
            chk("rst_a_occ", 192'(a_occ), 192'(0));
            chk("rst_a_ready", 192'(a_up_ready), 192'(1));
            chk("rst_b_valid", 192'(b_dn_valid), 192'(0));
            step();
        end
        nrst = 1'b1;

        // streaming 1..5
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, DW'(k), 4'h5, 1'b1, 1'b0);
            if (k > 1) begin
                chk("strm_a_data", 192'(a_dn_data), 192'(k - 1));
                chk("strm_a_occ", 192'(a_occ), 192'(1));
                chk("strm_b_data", 192'(b_dn_data), 192'(k - 1));
            end
            step();
        end
        drive(1'b0, '0, 4'h0, 1'b1, 1'b0);
        chk("strm_last", 192'(a_dn_data), 192'(5));
        step();

        // stall: A, B, C with dn_ready low
        drive(1'b1, A_D, 4'h1, 1'b0, 1'b0);
        step();
        drive(1'b1, B_D, 4'h2, 1'b0, 1'b0);
        chk("s0_stall_ready", 192'(b_up_ready), 192'(0));
        chk("s0_stall_data", 192'(b_dn_data), 192'(A_D));
        chk("stall_a_ready1", 192'(a_up_ready), 192'(1));
        step();
        drive(1'b1, C_D, 4'h3, 1'b0, 1'b0);
        chk("stall_occ2", 192'(a_occ), 192'(2));
        chk("stall_ready0", 192'(a_up_ready), 192'(0));
        chk("stall_a_head", 192'(a_dn_data), 192'(A_D));
        chk("stall_a_ctrl", 192'(a_dn_ctrl), 192'(1));
        step();
        drive(1'b1, C_D, 4'h3, 1'b1, 1'b0);
        chk("order_A", 192'(a_dn_data), 192'(A_D));
        step();
        drive(1'b1, C_D, 4'h3, 1'b1, 1'b0);
        chk("order_B", 192'(a_dn_data), 192'(B_D));
        chk("order_B_valid", 192'(a_dn_valid), 192'(1));
        step();
        drive(1'b1, E_D, 4'h4, 1'b0, 1'b0);
        chk("order_C", 192'(a_dn_data), 192'(C_D));
        chk("order_C_ctrl", 192'(a_dn_ctrl), 192'(3));
        step();

        // flush with a full stage and beat D offered
        drive(1'b1, D_D, 4'h7, 1'b0, 1'b1);
        chk("flush_pre_occ", 192'(a_occ), 192'(2));
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 4'h0, 1'b1, 1'b0);
            chk("flush_a_valid", 192'(a_dn_valid), 192'(0));
            chk("flush_a_ctrl", 192'(a_dn_ctrl), 192'(0));
            chk("flush_a_occ", 192'(a_occ), 192'(0));
            chk("flush_b_valid", 192'(b_dn_valid), 192'(0));
            step();
        end

        // bubbles carrying ctrl=F
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rnd(), 4'hF, 1'($urandom), 1'b0);
            chk("bub_a_ctrl", 192'(a_dn_ctrl), 192'(0));
            chk("bub_b_ctrl", 192'(b_dn_ctrl), 192'(0));
            step();
        end

        // async reset in the middle of a SKID=0 stall
        drive(1'b1, X_D, 4'h6, 1'b0, 1'b0);
        step();
        drive(1'b1, Y_D, 4'h6, 1'b0, 1'b0);
        chk("s0_hold_valid", 192'(b_dn_valid), 192'(1));
        chk("s0_hold_ready", 192'(b_up_ready), 192'(0));
        chk("s0_hold_data", 192'(b_dn_data), 192'(X_D));
        step();
        drive(1'b1, Y_D, 4'h6, 1'b0, 1'b0);
        chk("s0_stable_data", 192'(b_dn_data), 192'(X_D));
        #2;
        nrst = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("arst_b_valid", 192'(b_dn_valid), 192'(0));
        chk("arst_b_ctrl", 192'(b_dn_ctrl), 192'(0));
        chk("arst_a_valid", 192'(a_dn_valid), 192'(0));
        chk("arst_a_occ", 192'(a_occ), 192'(0));
        step();
        nrst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                nrst = 1'b0;
                qa.delete();
                qb.delete();
            end else begin
                nrst = 1'b1;
            end
            drive(($urandom_range(0, 3) != 0), rnd(), 4'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
            step();
        end
        nrst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
